// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings,
// default latencies, controller state type and decode helpers.
package mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'b000,
    MDU_MULT  = 3'b001,
    MDU_MULTU = 3'b010,
    MDU_DIV   = 3'b011,
    MDU_DIVU  = 3'b100,
    MDU_MTHI  = 3'b101,
    MDU_MTLO  = 3'b110
  } mdu_op_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  // Ops that occupy the unit for a fixed number of cycles.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Pipeline <-> MDU signal bundle. The pipeline side is the master; the
// multiply/divide controller is the slave.
interface mdu_ctrl_if;
  logic        req;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_md_use;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output req, start, mdu_op, a, b, d_md_use,
    input  busy, stall_md, hi, lo
  );

  modport slave (
    input  req, start, mdu_op, a, b, d_md_use,
    output busy, stall_md, hi, lo
  );
endinterface

// File: rtl/mdu_calc.sv
// Combinational MDU datapath: signed/unsigned 32x32 multiply and divide.
// A zero divisor returns the current HI/LO so the commit leaves them unchanged.
module mdu_calc
  import mdu_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        signed_div;
  logic        b_zero;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    prod_s     = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u     = {32'd0, a} * {32'd0, b};
    signed_div = (op == MDU_DIV);
    b_zero     = (b == 32'd0);

    // Signed divide runs on magnitudes; 0x80000000 stays 0x80000000 as an
    // unsigned magnitude, which makes the -2^31 / -1 case wrap naturally.
    div_a = (signed_div && a[31]) ? (32'd0 - a) : a;
    div_b = (signed_div && b[31]) ? (32'd0 - b) : b;
    quot  = b_zero ? 32'd0 : (div_a / div_b);
    rem   = b_zero ? 32'd0 : (div_a % div_b);

    res_hi = hi;
    res_lo = lo;
    case (op)
      MDU_MULT:  {res_hi, res_lo} = prod_s;
      MDU_MULTU: {res_hi, res_lo} = prod_u;
      MDU_DIV: begin
        if (!b_zero) begin
          res_lo = (a[31] ^ b[31]) ? (32'd0 - quot) : quot;
          res_hi = a[31] ? (32'd0 - rem) : rem;
        end
      end
      MDU_DIVU: begin
        if (!b_zero) begin
          res_lo = quot;
          res_hi = rem;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide controller: accepts MDU ops, holds the result in
// shadow registers for a fixed latency, owns HI/LO and drives the D-stage stall.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  mdu_ctrl_if.slave   bus
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  state_e             state;
  logic [CNT_W-1:0]   count;
  logic               busy_q;
  logic [31:0]        hi_q;
  logic [31:0]        lo_q;
  logic [31:0]        shadow_hi;
  logic [31:0]        shadow_lo;
  logic [31:0]        calc_hi;
  logic [31:0]        calc_lo;
  logic               arith_op;
  logic               issue_ok;
  logic               accept;

  assign arith_op = is_arith(bus.mdu_op);
  assign issue_ok = bus.start && !bus.req && !busy_q;
  assign accept   = issue_ok && arith_op;

  mdu_calc u_calc (
    .op     (bus.mdu_op),
    .a      (bus.a),
    .b      (bus.b),
    .hi     (hi_q),
    .lo     (lo_q),
    .res_hi (calc_hi),
    .res_lo (calc_lo)
  );

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: shadows are cleared with the architectural registers so a
      // dropped operation can never leak a stale result later.
      state     <= ST_IDLE;
      count     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      shadow_hi <= '0;
      shadow_lo <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shadow_hi <= calc_hi;
            shadow_lo <= calc_lo;
            count     <= is_div(bus.mdu_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            busy_q    <= 1'b1;
            state     <= ST_RUN;
          end else if (issue_ok && bus.mdu_op == MDU_MTHI) begin
            hi_q <= bus.a;
          end else if (issue_ok && bus.mdu_op == MDU_MTLO) begin
            lo_q <= bus.a;
          end
        end
        ST_RUN: begin
          // The last busy cycle commits, so HI/LO are fresh the first cycle busy drops.
          if (count == CNT_W'(1)) begin
            hi_q   <= shadow_hi;
            lo_q   <= shadow_lo;
            busy_q <= 1'b0;
            count  <= '0;
            state  <= ST_IDLE;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  // Includes the accept cycle so the following MDU instruction cannot enter E.
  assign bus.stall_md = bus.d_md_use && (busy_q || (bus.start && arith_op));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: a reference model pushes expected HI/LO
// and latency into a scoreboard that is popped when busy falls.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk;
  logic reset;

  mdu_ctrl_if bus ();

  mdu_ctrl #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] cur_hi = 32'd0;
  logic [31:0] cur_lo = 32'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // The pipeline must never issue an MDU op into a busy unit.
  always @(negedge clk) begin
    if (!reset && bus.busy && bus.start)
      $error("start asserted while busy (op=%0d)", bus.mdu_op);
  end

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    int                sa;
    int                sb_v;
    longint            ps;
    longint unsigned   pu;
    int                q;
    int                r;
    sa   = int'(a);
    sb_v = int'(b);
    case (op)
      MDU_MULT: begin
        ps = longint'(sa) * longint'(sb_v);
        return 64'(ps);
      end
      MDU_MULTU: begin
        pu = longint'({32'd0, a}) * longint'({32'd0, b});
        return 64'(pu);
      end
      MDU_DIV: begin
        if (b == 32'd0) return {hi, lo};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sb_v;
        r = sa % sb_v;
        return {32'(r), 32'(q)};
      end
      MDU_DIVU: begin
        if (b == 32'd0) return {hi, lo};
        return {a % b, a / b};
      end
      default: return {hi, lo};
    endcase
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic d_use);
    exp_t        e;
    logic [63:0] r;
    int          n;
    r        = model(op, a, b, cur_hi, cur_lo);
    e.hi     = r[63:32];
    e.lo     = r[31:0];
    e.cycles = (op == MDU_DIV || op == MDU_DIVU) ? DIV_N : MULT_N;
    sb.push_back(e);

    @(negedge clk);
    bus.start    = 1'b1;
    bus.mdu_op   = op;
    bus.a        = a;
    bus.b        = b;
    bus.d_md_use = d_use;
    #1 check("stall_accept", 64'(bus.stall_md), 64'(d_use));

    @(negedge clk);
    bus.start  = 1'b0;
    bus.mdu_op = MDU_NONE;
    n = 0;
    while (bus.busy && n < 100) begin
      check("stall_busy", 64'(bus.stall_md), 64'(d_use));
      n++;
      @(negedge clk);
    end
    e = sb.pop_front();
    check("busy_cycles", 64'(n), 64'(e.cycles));
    check("hi", 64'(bus.hi), 64'(e.hi));
    check("lo", 64'(bus.lo), 64'(e.lo));
    cur_hi       = e.hi;
    cur_lo       = e.lo;
    bus.d_md_use = 1'b0;
  endtask

  task automatic do_mt(input logic [2:0] op, input logic [31:0] a, input logic rq);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.req    = rq;
    bus.mdu_op = op;
    bus.a      = a;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.req    = 1'b0;
    bus.mdu_op = MDU_NONE;
    if (!rq) begin
      if (op == MDU_MTHI) cur_hi = a;
      else                cur_lo = a;
    end
    check("mt_busy", 64'(bus.busy), 64'd0);
    check("mt_hi", 64'(bus.hi), 64'(cur_hi));
    check("mt_lo", 64'(bus.lo), 64'(cur_lo));
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    reset        = 1'b1;
    bus.req      = 1'b0;
    bus.start    = 1'b0;
    bus.mdu_op   = MDU_NONE;
    bus.a        = 32'd0;
    bus.b        = 32'd0;
    bus.d_md_use = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_stall", 64'(bus.stall_md), 64'd0);
    reset = 1'b0;

    do_op(MDU_MULT,  32'hFFFF_FFFE, 32'd3, 1'b1);
    do_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    do_op(MDU_DIV,   32'hFFFF_FFF9, 32'd2, 1'b1);
    do_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    do_mt(MDU_MTHI, 32'h11, 1'b0);
    do_mt(MDU_MTLO, 32'h22, 1'b0);
    do_op(MDU_DIVU, 32'd5, 32'd0, 1'b1);
    do_op(MDU_DIV,  32'd9, 32'd0, 1'b0);

    // Flushed MULT: nothing starts and HI/LO hold.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.req      = 1'b1;
    bus.mdu_op   = MDU_MULT;
    bus.a        = 32'd5;
    bus.b        = 32'd7;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.req    = 1'b0;
    bus.mdu_op = MDU_NONE;
    check("req_busy", 64'(bus.busy), 64'd0);
    check("req_hi", 64'(bus.hi), 64'(cur_hi));
    check("req_lo", 64'(bus.lo), 64'(cur_lo));
    do_mt(MDU_MTLO, 32'h1234, 1'b0);
    do_mt(MDU_MTHI, 32'hDEAD_BEEF, 1'b1);

    for (int i = 0; i < 6; i++) begin
      rop = 3'($urandom_range(1, 4));
      ra  = $urandom;
      rb  = (i == 3) ? 32'd0 : $urandom;
      do_op(rop, ra, rb, 1'($urandom_range(0, 1)));
    end

    // Reset during busy cycle 4 drops the operation without a late write.
    do_op(MDU_MULTU, 32'h1_0001, 32'h3_0003, 1'b0);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mdu_op = MDU_DIV;
    bus.a      = 32'd100;
    bus.b      = 32'd7;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.mdu_op = MDU_NONE;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_hi", 64'(bus.hi), 64'd0);
    check("mid_rst_lo", 64'(bus.lo), 64'd0);
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    repeat (12) @(negedge clk);
    check("late_busy", 64'(bus.busy), 64'd0);
    check("late_hi", 64'(bus.hi), 64'd0);
    check("late_lo", 64'(bus.lo), 64'd0);

    do_op(MDU_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
